// File: rtl/uart_pkt_loader.sv
// uart_pkt_loader: frames UART bytes into checksummed packets and writes the payload to memory
module uart_pkt_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1280,
  parameter int         CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  output logic       rx_enable,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       wr_en,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_FINISH} state_t;
  state_t state, state_n;
  logic [7:0] base, base_n, len, len_n, idx, idx_n, chk, chk_n, addr_n, data_n;
  logic good, good_n, pend_valid, pend_n, ok_n, err_n;
  logic [1:0] code_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic counting, overrun, capture, expire;
  assign wr_en = pend_valid;
  assign busy = (state != S_IDLE) || pend_valid;
  always_comb begin
    counting = state inside {S_ADDR, S_LEN, S_DATA, S_CHK};
    overrun = rx_done && state == S_DATA && pend_valid && !wr_ready;
    capture = rx_done && state == S_DATA && !overrun;
    // expiry fires on the edge where the counter would reach TIMEOUT-1
    expire = counting && !rx_done && cnt == CNT_W'(TIMEOUT - 2);
    cnt_n = (counting && !rx_done && !expire) ? cnt + CNT_W'(1) : '0;
    pend_n = capture || (pend_valid && !wr_ready);
    addr_n = capture ? base + idx : wr_addr;
    data_n = capture ? rx_data : wr_data;
    state_n = state;
    base_n = base;
    len_n = len;
    idx_n = idx;
    chk_n = chk;
    good_n = good;
    ok_n = 1'b0;
    err_n = 1'b0;
    code_n = err_code;
    case (state)
      S_IDLE: state_n = (rx_done && rx_data == SYNC_BYTE && ctrl_en) ? S_ADDR : S_IDLE;
      S_ADDR: if (rx_done) begin
        base_n = rx_data;
        chk_n = rx_data;
        state_n = S_LEN;
      end
      S_LEN: if (rx_done) begin
        len_n = rx_data;
        chk_n = chk ^ rx_data;
        idx_n = 8'd0;
        state_n = (rx_data != 8'd0) ? S_DATA : S_CHK;
      end
      S_DATA: if (overrun) begin
        err_n = 1'b1;
        code_n = 2'd3;
        state_n = S_IDLE;
      end else if (rx_done) begin
        chk_n = chk ^ rx_data;
        idx_n = idx + 8'd1;
        state_n = (idx + 8'd1 == len) ? S_CHK : S_DATA;
      end
      S_CHK: if (rx_done) begin
        good_n = rx_data == chk;
        state_n = S_FINISH;
      end
      S_FINISH: if (!pend_valid) begin
        ok_n = good;
        err_n = !good;
        code_n = good ? 2'd0 : 2'd1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (expire) begin
      err_n = 1'b1;
      code_n = 2'd2;
      state_n = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rx_enable <= 1'b0;
      base <= '0;
      len <= '0;
      idx <= '0;
      chk <= '0;
      good <= 1'b0;
      cnt <= '0;
      pend_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      pkt_ok <= 1'b0;
      pkt_err <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_n;
      rx_enable <= ctrl_en;
      base <= base_n;
      len <= len_n;
      idx <= idx_n;
      chk <= chk_n;
      good <= good_n;
      cnt <= cnt_n;
      pend_valid <= pend_n;
      wr_addr <= addr_n;
      wr_data <= data_n;
      pkt_ok <= ok_n;
      pkt_err <= err_n;
      err_code <= code_n;
    end
  end
endmodule

// File: doc/uart_pkt_loader.md
Name: uart_pkt_loader

Overview:
- Packet sequencer between the UART receiver (8-bit `data_out` / one-cycle `done` pulse) and the neural-network weight/input memory write port.
- Parses host byte stream into framed packets and enables the receiver.
- Writes each payload byte to memory with a ready/valid handshake.
- Checks an XOR checksum and a byte-gap timeout, and reports packet completion or error to the top-level controller.

Parameters:
SYNC_BYTE, 8'hA5, packet start marker
TIMEOUT, 1280, max clk cycles between bytes inside a packet (4 byte times at 32 clk/bit)
CNT_W, 11, width of timeout counter; must hold TIMEOUT-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ctrl_en  input  1  host-side enable; 0 stops new packets
rx_enable  output  1  drives UART receiver enable
rx_data  input  8  received byte, valid only when rx_done=1
rx_done  input  1  one-cycle pulse per received byte
wr_en  output  1  memory write request (valid)
wr_ready  input  1  memory accepts write when wr_en&&wr_ready
wr_addr  output  8  write address
wr_data  output  8  write data
busy  output  1  1 in any state except IDLE, or write pending
pkt_ok  output  1  one-cycle pulse: packet complete, checksum good
pkt_err  output  1  one-cycle pulse: packet aborted/bad
err_code  output  2  valid with pkt_err, held until next pkt_ok/pkt_err: 1=checksum, 2=timeout, 3=overrun

Behaviour:
- Frame: SYNC, ADDR, LEN, LEN payload bytes, CHK.
  - CHK = XOR of ADDR, LEN and all payload bytes.
  - LEN=0 is legal: no writes; CHK follows LEN directly.
- Reset state:
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, pkt_ok=0, pkt_err=0, err_code=0, busy=0, rx_enable=0.
  - Internals: FSM=IDLE, pend_valid=0, counters=0.
- Reset mid-packet: abandon all progress.
  - No pulse is issued.
  - Any pending write is dropped.
- rx_enable is registered: equals ctrl_en one cycle later; 0 during rst.
- FSM states: IDLE, ADDR, LEN, DATA, CHK, FINISH.
  - IDLE: on rx_done with rx_data==SYNC_BYTE and ctrl_en=1 -> ADDR. Other bytes ignored; stay IDLE.
  - ADDR: on rx_done, latch base address, chk=rx_data -> LEN.
  - LEN: on rx_done, latch len, chk^=rx_data, idx=0 -> DATA if len!=0, else CHK.
  - DATA: on rx_done:
    - capture pend_data=rx_data, pend_addr=base+idx (8-bit wrap), pend_valid=1.
    - chk^=rx_data, idx++.
    - when idx reaches len -> CHK.
  - CHK: on rx_done, result = (rx_data==chk) -> FINISH.
  - FINISH: wait until pend_valid=0, then pulse pkt_ok (good) or pkt_err with err_code=1 (bad) for one cycle -> IDLE.
- Write handshake:
  - wr_en=pend_valid; wr_addr/wr_data are registered from pend_addr/pend_data.
  - First wr_en is the cycle after the rx_done that carried the byte.
  - pend_valid clears on wr_en&&wr_ready unless a new byte is captured that same cycle; the new byte wins and pend_valid stays 1.
  - wr_addr/wr_data stable while wr_en=1 and wr_ready=0.
- Overrun: rx_done in DATA while pend_valid=1 and wr_ready=0.
  - Pulse pkt_err next cycle with err_code=3 -> IDLE.
  - The old pending write still completes; the new byte is discarded.
- Timeout:
  - Counter clears on every rx_done; counts only in ADDR/LEN/DATA/CHK.
  - On reaching TIMEOUT-1 with no rx_done: pkt_err pulse, err_code=2 -> IDLE. A pending write still drains.
- Simultaneous rx_done and timeout expiry: rx_done wins; no timeout.
- ctrl_en=0 does not abort a packet in progress. rx_enable drops, so such a packet normally ends by timeout.
- Checksum errors do not undo writes already performed; the host must resend.
- pkt_ok and pkt_err are never both 1.

Test Plan:
- Good packet: A5,10,03,01,02,03,13 with wr_ready=1 -> writes (10,01),(11,02),(12,03), each wr_en one cycle after its rx_done; one pkt_ok pulse; err_code=0.
- Address wrap and zero length: A5,FE,03,AA,BB,CC,(FE^03^AA^BB^CC) -> writes to FE,FF,00, pkt_ok. Then A5,20,00,20 -> no writes, pkt_ok.
- Bad checksum and noise: stray bytes 00,FF before A5,10,01,55,00 -> strays ignored; write (10,55); pkt_err with err_code=1.
- Backpressure and overrun: hold wr_ready=0 during DATA.
  - First byte: wr_en stays high, addr/data stable.
  - Second rx_done while held -> pkt_err, err_code=3.
  - Release wr_ready -> only the first write completes.
- Timeout: A5,10 then silence -> pkt_err with err_code=2 exactly TIMEOUT cycles after the last rx_done. A following good packet is then accepted normally.
- Reset mid-DATA: assert rst for 1 cycle with pend_valid=1 -> next cycle wr_en=0, busy=0, no pulse, rx_enable=0. A fresh packet afterwards succeeds.
